// File: rtl/riscv_pkg.sv
// Purpose: shared constants for the RISC-V pipeline front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  // addi x0, x0, 0 -- the canonical bubble placed in IF/ID.
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  // Every instruction is one 32-bit word; PCs advance by this many bytes.
  localparam int INST_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_register.sv
// Purpose: IF/ID pipeline register with hold and flush controls.
// Latency: 1 cycle from load_* inputs to registered outputs.
// Backpressure: hold freezes contents; flush/reset force a bubble and beat hold.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   hold                   keep current contents (stall from the hazard unit)
//   flush                  replace contents with a bubble (wrong-path fetch)
//   load_*                 fetched PC, PC+4 and instruction word to capture
//   valid, pc, pc_plus4,   registered IF/ID contents; instruction is NOP
//   instruction            and pc/pc_plus4 are zero while valid=0
module if_id_register
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] load_pc,
  input  logic [DATA_WIDTH-1:0] load_pc_plus4,
  input  logic [DATA_WIDTH-1:0] load_instruction,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] instruction
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTRUCTION);

  // Reset and flush both leave a bubble, so they share one branch; it sits
  // above hold so a redirect during a stall still discards the wrong path.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid       <= 1'b0;
      pc          <= '0;
      pc_plus4    <= '0;
      instruction <= NOP;
    end else if (!hold) begin
      valid       <= 1'b1;
      pc          <= load_pc;
      pc_plus4    <= load_pc_plus4;
      instruction <= load_instruction;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch: PC register, next-PC select, IF/ID capture, fetch counter.
// Latency: word addressed in cycle N appears on if_id_* after the edge ending cycle N.
// Backpressure: stall holds PC, IF/ID and count; redirect overrides stall and flushes IF/ID.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   stall                           hazard-unit hold request
//   redirect_valid/_target          taken branch or jump resolved in EX
//   imem_address/imem_instruction   combinational instruction memory port
//   if_id_*                         IF/ID pipeline register contents
//   fetch_count                     valid captures into IF/ID since reset (wraps)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic [DATA_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_pc,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [31:0]           fetch_count
);

  // Clears the byte-offset bits so the PC is always word aligned.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(INST_BYTES - 1);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  advance;

  // Modulo 2^DATA_WIDTH: the top word wraps to address 0.
  assign pc_plus4     = pc + DATA_WIDTH'(INST_BYTES);
  assign imem_address = pc;
  assign advance      = !redirect_valid && !stall;

  // Redirect beats stall: the instruction held in ID is on the wrong path.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_valid) begin
      pc_next = redirect_target & ALIGN_MASK;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC & ALIGN_MASK;
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      if (advance) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk              (clk),
    .reset            (reset),
    .hold             (stall),
    .flush            (redirect_valid),
    .load_pc          (pc),
    .load_pc_plus4    (pc_plus4),
    .load_instruction (imem_instruction),
    .valid            (if_id_valid),
    .pc               (if_id_pc),
    .pc_plus4         (if_id_pc_plus4),
    .instruction      (if_id_instruction)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_target, imem_address, imem_instruction;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instruction, fetch_count;

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_instruction (if_id_instruction),
    .fetch_count       (fetch_count)
  );

  // Second DUT for the top-of-address-space wrap
  logic        w_reset, w_stall, w_redirect_valid;
  logic [31:0] w_redirect_target, w_imem_address, w_imem_instruction;
  logic        w_if_id_valid;
  logic [31:0] w_if_id_pc, w_if_id_pc_plus4, w_if_id_instruction, w_fetch_count;

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk               (clk),
    .reset             (w_reset),
    .stall             (w_stall),
    .redirect_valid    (w_redirect_valid),
    .redirect_target   (w_redirect_target),
    .imem_address      (w_imem_address),
    .imem_instruction  (w_imem_instruction),
    .if_id_valid       (w_if_id_valid),
    .if_id_pc          (w_if_id_pc),
    .if_id_pc_plus4    (w_if_id_pc_plus4),
    .if_id_instruction (w_if_id_instruction),
    .fetch_count       (w_fetch_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] ins;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
    logic [31:0] e_ins;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(logic rst, logic stl, logic rv, logic [31:0] tgt, logic [31:0] ins,
                              logic [31:0] e_addr, logic e_vld, logic [31:0] e_pc,
                              logic [31:0] e_p4, logic [31:0] e_ins, logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.tgt = tgt; v.ins = ins;
    v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_p4 = e_p4;
    v.e_ins = e_ins; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    // Inputs applied before an edge; expected outputs sampled 1 time unit after it.
    //                rst  stl  rv   target        mem word        addr          vld  if_id_pc      pc+4          instr         count
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,        32'h0,          32'h0000_0000,1'b0,32'h0,        32'h0,        32'h0000_0013,32'd0); // reset
    vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h0050_0093,  32'h0000_0004,1'b1,32'h0,        32'h4,        32'h0050_0093,32'd1);
    vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h00A0_0113,  32'h0000_0008,1'b1,32'h4,        32'h8,        32'h00A0_0113,32'd2);
    vecs[3]  = mk(1'b0,1'b1,1'b0,32'h0,        32'h0020_81B3,  32'h0000_0008,1'b1,32'h4,        32'h8,        32'h00A0_0113,32'd2); // stall
    vecs[4]  = mk(1'b0,1'b1,1'b0,32'h0,        32'h0020_81B3,  32'h0000_0008,1'b1,32'h4,        32'h8,        32'h00A0_0113,32'd2); // stall
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h0020_81B3,  32'h0000_000C,1'b1,32'h8,        32'hC,        32'h0020_81B3,32'd3); // refetch pc 8
    vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h0000_0013,  32'h0000_0010,1'b1,32'hC,        32'h10,       32'h0000_0013,32'd4);
    vecs[7]  = mk(1'b0,1'b0,1'b1,32'h40,       32'hDEAD_BEEF,  32'h0000_0040,1'b0,32'h0,        32'h0,        32'h0000_0013,32'd4); // redirect
    vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h1111_1111,  32'h0000_0044,1'b1,32'h40,       32'h44,       32'h1111_1111,32'd5);
    vecs[9]  = mk(1'b0,1'b1,1'b1,32'h23,       32'h2222_2222,  32'h0000_0020,1'b0,32'h0,        32'h0,        32'h0000_0013,32'd5); // redirect+stall, misaligned
    vecs[10] = mk(1'b0,1'b0,1'b1,32'h102,      32'h2323_2323,  32'h0000_0100,1'b0,32'h0,        32'h0,        32'h0000_0013,32'd5); // back-to-back redirect
    vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,        32'h3333_3333,  32'h0000_0104,1'b1,32'h100,      32'h104,      32'h3333_3333,32'd6);
    vecs[12] = mk(1'b1,1'b1,1'b0,32'h0,        32'h5555_5555,  32'h0000_0000,1'b0,32'h0,        32'h0,        32'h0000_0013,32'd0); // reset during stall
    vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,        32'h4444_4444,  32'h0000_0004,1'b1,32'h0,        32'h4,        32'h4444_4444,32'd1);
    vecs[14] = mk(1'b1,1'b0,1'b1,32'h80,       32'h6666_6666,  32'h0000_0000,1'b0,32'h0,        32'h0,        32'h0000_0013,32'd0); // reset beats redirect

    w_reset = 1'b1; w_stall = 1'b0; w_redirect_valid = 1'b0;
    w_redirect_target = 32'h0; w_imem_instruction = 32'h0;

    for (int i = 0; i < NV; i++) begin
      reset            = vecs[i].rst;
      stall            = vecs[i].stl;
      redirect_valid   = vecs[i].rv;
      redirect_target  = vecs[i].tgt;
      imem_instruction = vecs[i].ins;
      @(posedge clk);
      #1;
      chk("imem_address",      i, imem_address,      vecs[i].e_addr);
      chk("if_id_valid",       i, {31'b0, if_id_valid}, {31'b0, vecs[i].e_vld});
      chk("if_id_pc",          i, if_id_pc,          vecs[i].e_pc);
      chk("if_id_pc_plus4",    i, if_id_pc_plus4,    vecs[i].e_p4);
      chk("if_id_instruction", i, if_id_instruction, vecs[i].e_ins);
      chk("fetch_count",       i, fetch_count,       vecs[i].e_cnt);
    end

    // Wrap DUT: reset was held across the vector run; check reset PC.
    chk("wrap_reset_addr",  0, w_imem_address, 32'hFFFF_FFFC);
    chk("wrap_reset_cnt",   0, w_fetch_count,  32'd0);
    // One normal cycle at the top word: PC+4 wraps to zero.
    w_reset = 1'b0;
    w_imem_instruction = 32'h0070_0393;
    @(posedge clk);
    #1;
    chk("wrap_if_id_pc",    1, w_if_id_pc,          32'hFFFF_FFFC);
    chk("wrap_pc_plus4",    1, w_if_id_pc_plus4,    32'h0000_0000);
    chk("wrap_instruction", 1, w_if_id_instruction, 32'h0070_0393);
    chk("wrap_valid",       1, {31'b0, w_if_id_valid}, 32'd1);
    chk("wrap_addr",        1, w_imem_address,      32'h0000_0000);
    chk("wrap_cnt",         1, w_fetch_count,       32'd1);
    // Next fetch continues from address 0.
    w_imem_instruction = 32'h0000_0013;
    @(posedge clk);
    #1;
    chk("wrap_next_pc",     2, w_if_id_pc,     32'h0000_0000);
    chk("wrap_next_addr",   2, w_imem_address, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the PC and drives the instruction-memory address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register together with PC and PC+4.
- Handles stall from hazard detection and PC redirect/flush from the EX-stage branch/jump resolution.
- Instruction memory is combinational, so read data is valid in the same cycle as the address.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; holds PC and IF/ID contents.
- redirect_valid  input  1  from EX; a taken branch or jump resolved this cycle.
- redirect_target  input  DATA_WIDTH  from EX; new PC when redirect_valid=1.
- imem_address  output  DATA_WIDTH  to instruction memory; equals current PC.
- imem_instruction  input  DATA_WIDTH  from instruction memory; combinational read data.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- if_id_pc  output  DATA_WIDTH  PC of the instruction in IF/ID.
- if_id_pc_plus4  output  DATA_WIDTH  if_id_pc + 4.
- if_id_instruction  output  DATA_WIDTH  instruction word in IF/ID (NOP when bubble).
- fetch_count  output  32  number of instructions captured valid into IF/ID since reset.

Behaviour:
- **imem_address**
  - Combinational: imem_address = pc.
  - pc[1:0] is always 00.
- **Reset** (synchronous; sampled on clk rising edge while reset=1):
  - pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instruction=32'h0000_0013 (NOP), fetch_count=0.
  - Reset overrides every other input.
  - Reset asserted mid-operation discards the in-flight IF/ID contents the same edge.
- **Edge priority** (highest first): reset > redirect_valid > stall > normal.
- **Redirect** (redirect_valid=1):
  - Next pc = {redirect_target[DATA_WIDTH-1:2], 2'b00}; misaligned low bits are cleared.
  - IF/ID is flushed: valid=0, instruction=NOP, pc and pc_plus4 = 0.
  - Redirect wins over a simultaneous stall. The stalled ID instruction is on the wrong path; the hazard unit guarantees this.
  - fetch_count is not incremented.
- **Stall** (stall=1, redirect_valid=0):
  - pc and all IF/ID outputs and fetch_count hold their values.
  - The instruction currently presented by memory is re-fetched next cycle.
- **Normal**:
  - if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_instruction <= imem_instruction, if_id_valid <= 1, pc <= pc+4, fetch_count <= fetch_count+1.
- **Latency**: an instruction addressed in cycle N appears on the IF/ID outputs after the edge ending cycle N (1-cycle latency).
- **Arithmetic**:
  - PC+4 is modulo 2^DATA_WIDTH; pc=32'hFFFF_FFFC wraps to 0.
  - fetch_count wraps at 2^32.
- No internal state machine beyond the registers. The pipeline register has two conceptual states, VALID and BUBBLE, selected by the priority above.
- Back-to-back redirects on consecutive cycles each take effect; IF/ID remains a bubble throughout.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTRUCTION = 32'h0000_0013.
  - INST_BYTES = 4.
  - Default RESET_PC.
- Natural sub-module if_id_register: the clocked IF/ID register with hold (stall) and flush controls. fetch_stage instantiates it and keeps the PC register, next-PC mux and fetch_count.

Test Plan:
- Reset then 4 free-running cycles with memory returning 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 -> imem_address 0,4,8,12; IF/ID shows pc 0/4/8 with matching words, valid=1; fetch_count=4.
- Assert stall for 2 cycles at pc=8 -> imem_address stays 8, IF/ID holds pc=4 and its word, fetch_count unchanged. Release -> pc=8 is captured next edge.
- redirect_valid=1, redirect_target=0x40 at pc=0x10 -> next imem_address=0x40, if_id_valid=0, if_id_instruction=0x00000013. The following edge captures pc=0x40 valid.
- redirect_valid=1 and stall=1 in the same cycle, target=0x23 -> pc becomes 0x20 (low bits cleared), IF/ID flushed, stall ignored.
- RESET_PC=32'hFFFF_FFFC, one normal cycle -> if_id_pc=0xFFFFFFFC, if_id_pc_plus4=0, pc=0.
- Reset asserted for one cycle while if_id_valid=1 and stall=1 -> all outputs return to reset values at that edge; fetch_count=0.
